// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the register-rename stage: register widths,
// the decoded/renamed instruction records and the free-list index helper.
package rename_stage_pkg;

  localparam int NUM_AREGS  = 32;
  localparam int NUM_PREGS  = 128;
  localparam int AW         = $clog2(NUM_AREGS);
  localparam int PW         = $clog2(NUM_PREGS);
  localparam int FREE_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int FW         = $clog2(FREE_DEPTH);
  localparam int CW         = $clog2(FREE_DEPTH + 1);

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;

  typedef enum logic [3:0] {
    ADD_I,
    ADD,
    SUB,
    AND_I,
    OR_I,
    XOR_I,
    SLL,
    SRL,
    LOAD,
    STORE,
    BRANCH,
    JAL
  } opcode_e;

  typedef struct packed {
    areg_t       rd;
    areg_t       rs1;
    areg_t       rs2;
    logic        wr_reg;
    opcode_e     op;
    logic [31:0] imm;
    logic [3:0]  flags;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t instr;
    preg_t          prs1;
    preg_t          prs2;
    preg_t          prd;
    preg_t          old_prd;
  } decoded_rr_instr_t;

  // Circular index advance; the free list is not a power-of-two deep.
  function automatic logic [FW-1:0] fl_next(input logic [FW-1:0] idx);
    return (idx == FW'(FREE_DEPTH - 1)) ? '0 : idx + FW'(1);
  endfunction

endpackage

// File: rtl/rename_stage_if.sv
// Decode-to-dispatch bundle around the rename stage, plus commit free-return
// and the free-list status/occupancy seen by the neighbouring stages.
interface rename_stage_if;
  import rename_stage_pkg::*;

  // Handshake: an instruction on decoded_dd transfers at a rising edge where
  // valid_i=1, stall=0 and rename_stall_o=0; otherwise the upstream must hold it.
  // The renamed result appears on decoded_rr with rr_valid_o one cycle later.
  logic              stall;
  logic              valid_i;
  decoded_instr_t    decoded_dd;
  logic              free_w_en;
  preg_t             free_preg_i;
  areg_t             bypass_dst_i;
  preg_t             bypass_alias_i;

  decoded_rr_instr_t decoded_rr;
  logic              rr_valid_o;
  areg_t             bypass_dst_o;
  preg_t             bypass_alias_o;
  logic              rename_stall_o;
  logic              full;
  logic              empty;
  logic [CW-1:0]     free_count;

  modport master (
    output stall,
    output valid_i,
    output decoded_dd,
    output free_w_en,
    output free_preg_i,
    output bypass_dst_i,
    output bypass_alias_i,
    input  decoded_rr,
    input  rr_valid_o,
    input  bypass_dst_o,
    input  bypass_alias_o,
    input  rename_stall_o,
    input  full,
    input  empty,
    input  free_count
  );

  modport slave (
    input  stall,
    input  valid_i,
    input  decoded_dd,
    input  free_w_en,
    input  free_preg_i,
    input  bypass_dst_i,
    input  bypass_alias_i,
    output decoded_rr,
    output rr_valid_o,
    output bypass_dst_o,
    output bypass_alias_o,
    output rename_stall_o,
    output full,
    output empty,
    output free_count
  );

endinterface

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical registers. Comes out of reset holding every
// preg above the architectural range, in ascending order.
module preg_free_list
  import rename_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          w_en,
  input  logic          r_en,
  input  preg_t         preg_in,
  output preg_t         preg_out,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  preg_t         mem_q [FREE_DEPTH];
  preg_t         mem_d [FREE_DEPTH];
  logic [FW-1:0] head_q;
  logic [FW-1:0] head_d;
  logic [FW-1:0] tail_q;
  logic [FW-1:0] tail_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(FREE_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign preg_out = mem_q[head_q];

  // preg 0 is the hardwired zero register and must never re-enter circulation.
  assign do_push = w_en & ~full & (preg_in != '0);
  assign do_pop  = r_en & ~empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = preg_in;
      tail_d        = fl_next(tail_q);
    end
    if (do_pop) begin
      head_d = fl_next(head_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        mem_q[i] <= PW'(NUM_AREGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FREE_DEPTH);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup of sources, destination allocation from
// the free list, and the registered rename-to-dispatch pipeline slot.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rename_stage_if.slave io
);

  preg_t             rat_q [NUM_AREGS];
  preg_t             rat_d [NUM_AREGS];
  decoded_rr_instr_t rr_q;
  decoded_rr_instr_t rr_d;
  logic              rr_valid_q;
  logic              rr_valid_d;
  areg_t             byp_dst_q;
  areg_t             byp_dst_d;
  preg_t             byp_alias_q;
  preg_t             byp_alias_d;

  logic              needs_alloc;
  logic              rename_stall;
  logic              accept;
  logic              fl_pop;
  logic              fl_full;
  logic              fl_empty;
  logic [CW-1:0]     fl_count;
  preg_t             fl_head;
  preg_t             prs1;
  preg_t             prs2;
  preg_t             prd;
  preg_t             old_prd;

  // The bypass covers a mapping produced elsewhere that the RAT has not yet seen.
  function automatic preg_t src_lookup(input areg_t a, input areg_t bdst,
                                       input preg_t balias, input preg_t map);
    if (a == '0) begin
      return '0;
    end else if (bdst != '0 && bdst == a) begin
      return balias;
    end
    return map;
  endfunction

  preg_free_list u_free_list (
    .clk      (clk),
    .rst      (rst),
    .w_en     (io.free_w_en),
    .r_en     (fl_pop),
    .preg_in  (io.free_preg_i),
    .preg_out (fl_head),
    .full     (fl_full),
    .empty    (fl_empty),
    .count    (fl_count)
  );

  assign needs_alloc  = io.valid_i & io.decoded_dd.wr_reg & (io.decoded_dd.rd != '0);
  // Uses the pre-edge empty flag: a preg freed this cycle is usable next cycle.
  assign rename_stall = io.valid_i & needs_alloc & fl_empty;
  assign accept       = io.valid_i & ~io.stall & ~rename_stall;
  assign fl_pop       = accept & needs_alloc;

  assign prs1    = src_lookup(io.decoded_dd.rs1, io.bypass_dst_i, io.bypass_alias_i,
                              rat_q[io.decoded_dd.rs1]);
  assign prs2    = src_lookup(io.decoded_dd.rs2, io.bypass_dst_i, io.bypass_alias_i,
                              rat_q[io.decoded_dd.rs2]);
  assign prd     = needs_alloc ? fl_head : '0;
  assign old_prd = (io.decoded_dd.rd == '0) ? '0 : rat_q[io.decoded_dd.rd];

  always_comb begin
    rat_d       = rat_q;
    rr_d        = rr_q;
    rr_valid_d  = rr_valid_q;
    byp_dst_d   = byp_dst_q;
    byp_alias_d = byp_alias_q;
    if (fl_pop) begin
      rat_d[io.decoded_dd.rd] = fl_head;
    end
    if (accept) begin
      rr_d.instr   = io.decoded_dd;
      rr_d.prs1    = prs1;
      rr_d.prs2    = prs2;
      rr_d.prd     = prd;
      rr_d.old_prd = old_prd;
      rr_valid_d   = 1'b1;
      if (needs_alloc) begin
        byp_dst_d   = io.decoded_dd.rd;
        byp_alias_d = prd;
      end else begin
        byp_dst_d   = '0;
      end
    end else if (!io.stall) begin
      rr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        rat_q[i] <= PW'(i);
      end
      rr_q        <= '0;
      rr_valid_q  <= 1'b0;
      byp_dst_q   <= '0;
      byp_alias_q <= '0;
    end else begin
      rat_q       <= rat_d;
      rr_q        <= rr_d;
      rr_valid_q  <= rr_valid_d;
      byp_dst_q   <= byp_dst_d;
      byp_alias_q <= byp_alias_d;
    end
  end

  assign io.decoded_rr     = rr_q;
  assign io.rr_valid_o     = rr_valid_q;
  assign io.bypass_dst_o   = byp_dst_q;
  assign io.bypass_alias_o = byp_alias_q;
  assign io.rename_stall_o = rename_stall;
  assign io.full           = fl_full;
  assign io.empty          = fl_empty;
  assign io.free_count     = fl_count;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios with fixed expectations plus a
// randomized run against a queue/array reference model of renaming.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_stage_if bus();

  rename_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural map, free pregs in allocation order, outputs.
  int                m_rat [NUM_AREGS];
  logic [PW-1:0]     exp_q [$];
  decoded_rr_instr_t m_rr;
  logic              m_rr_valid;
  logic [AW-1:0]     m_byp_dst;
  logic [PW-1:0]     m_byp_alias;

  task automatic model_reset();
    for (int i = 0; i < NUM_AREGS; i++) m_rat[i] = i;
    exp_q.delete();
    for (int i = NUM_AREGS; i < NUM_PREGS; i++) exp_q.push_back(PW'(i));
    m_rr        = '0;
    m_rr_valid  = 1'b0;
    m_byp_dst   = '0;
    m_byp_alias = '0;
  endtask

  function automatic logic [PW-1:0] m_lookup(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.bypass_dst_i != 0 && bus.bypass_dst_i == a) return bus.bypass_alias_i;
    return PW'(m_rat[a]);
  endfunction

  function automatic bit m_alloc();
    return bus.valid_i && bus.decoded_dd.wr_reg && (bus.decoded_dd.rd != 0);
  endfunction

  function automatic bit m_rstall();
    return m_alloc() && (exp_q.size() == 0);
  endfunction

  task automatic model_step();
    bit            acc;
    bit            push;
    logic [PW-1:0] new_prd;
    if (rst) begin
      model_reset();
      return;
    end
    acc  = bus.valid_i && !bus.stall && !m_rstall();
    push = bus.free_w_en && (bus.free_preg_i != 0) && (exp_q.size() < FREE_DEPTH);
    if (acc) begin
      new_prd = '0;
      if (m_alloc()) new_prd = exp_q.pop_front();
      m_rr.instr   = bus.decoded_dd;
      m_rr.prs1    = m_lookup(bus.decoded_dd.rs1);
      m_rr.prs2    = m_lookup(bus.decoded_dd.rs2);
      m_rr.prd     = new_prd;
      m_rr.old_prd = (bus.decoded_dd.rd == 0) ? '0 : PW'(m_rat[bus.decoded_dd.rd]);
      m_rr_valid   = 1'b1;
      if (m_alloc()) begin
        m_rat[bus.decoded_dd.rd] = new_prd;
        m_byp_dst   = bus.decoded_dd.rd;
        m_byp_alias = new_prd;
      end else begin
        m_byp_dst = '0;
      end
    end else if (!bus.stall) begin
      m_rr_valid = 1'b0;
    end
    if (push) exp_q.push_back(bus.free_preg_i);
  endtask

  // Clock / driver tasks
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.valid_i        = 1'b0;
    bus.stall          = 1'b0;
    bus.free_w_en      = 1'b0;
    bus.free_preg_i    = '0;
    bus.bypass_dst_i   = '0;
    bus.bypass_alias_i = '0;
    bus.decoded_dd     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic decoded_instr_t mk(input int rd, input int rs1, input int rs2, input bit wr);
    decoded_instr_t d;
    d.rd     = AW'(rd);
    d.rs1    = AW'(rs1);
    d.rs2    = AW'(rs2);
    d.wr_reg = wr;
    d.op     = opcode_e'($urandom_range(0, 11));
    d.imm    = $urandom();
    d.flags  = 4'($urandom_range(0, 15));
    return d;
  endfunction

  task automatic issue(input decoded_instr_t d);
    bus.valid_i    = 1'b1;
    bus.decoded_dd = d;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.rr_valid_o !== 1'b0) $display("FAIL reset_rr_valid: got %0b want 0", bus.rr_valid_o); else n_pass++;
    n_checks++; if (bus.decoded_rr !== '0) $display("FAIL reset_decoded_rr: got %h want 0", bus.decoded_rr); else n_pass++;
    n_checks++; if (bus.bypass_dst_o !== 5'd0) $display("FAIL reset_byp_dst: got %0d want 0", bus.bypass_dst_o); else n_pass++;
    n_checks++; if (bus.bypass_alias_o !== 7'd0) $display("FAIL reset_byp_alias: got %0d want 0", bus.bypass_alias_o); else n_pass++;
    n_checks++; if (bus.free_count !== 7'd96) $display("FAIL reset_count: got %0d want 96", bus.free_count); else n_pass++;
    n_checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0) $display("FAIL reset_flags: got full=%0b empty=%0b want 1/0", bus.full, bus.empty); else n_pass++;
  endtask

  task automatic test_basic_rename();
    decoded_instr_t d;
    d = mk(1, 2, 3, 1);
    bus.valid_i = 1'b1; bus.decoded_dd = d; #1;
    n_checks++; if (bus.rename_stall_o !== 1'b0) $display("FAIL basic_no_stall: got %0b want 0", bus.rename_stall_o); else n_pass++;
    cycle();
    n_checks++; if (bus.rr_valid_o !== 1'b1) $display("FAIL basic_rr_valid: got %0b want 1", bus.rr_valid_o); else n_pass++;
    n_checks++; if (bus.decoded_rr.instr !== d) $display("FAIL basic_passthru: got %h want %h", bus.decoded_rr.instr, d); else n_pass++;
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd2 || bus.decoded_rr.prs2 !== 7'd3) $display("FAIL basic_srcs: got %0d/%0d want 2/3", bus.decoded_rr.prs1, bus.decoded_rr.prs2); else n_pass++;
    n_checks++; if (bus.decoded_rr.prd !== 7'd32 || bus.decoded_rr.old_prd !== 7'd1) $display("FAIL basic_dst: got prd=%0d old=%0d want 32/1", bus.decoded_rr.prd, bus.decoded_rr.old_prd); else n_pass++;
    n_checks++; if (bus.bypass_dst_o !== 5'd1 || bus.bypass_alias_o !== 7'd32) $display("FAIL basic_bypass_out: got %0d/%0d want 1/32", bus.bypass_dst_o, bus.bypass_alias_o); else n_pass++;
    issue(mk(16, 1, 4, 1));
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd32 || bus.decoded_rr.prs2 !== 7'd4) $display("FAIL rat_update_srcs: got %0d/%0d want 32/4", bus.decoded_rr.prs1, bus.decoded_rr.prs2); else n_pass++;
    n_checks++; if (bus.decoded_rr.prd !== 7'd33 || bus.decoded_rr.old_prd !== 7'd16) $display("FAIL rat_update_dst: got prd=%0d old=%0d want 33/16", bus.decoded_rr.prd, bus.decoded_rr.old_prd); else n_pass++;
    bus.bypass_dst_i = 5'd8; bus.bypass_alias_i = 7'd127;
    issue(mk(9, 8, 0, 0));
    bus.bypass_dst_i = '0; bus.bypass_alias_i = '0;
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd127 || bus.decoded_rr.prs2 !== 7'd0) $display("FAIL bypass_in: got %0d/%0d want 127/0", bus.decoded_rr.prs1, bus.decoded_rr.prs2); else n_pass++;
    n_checks++; if (bus.decoded_rr.prd !== 7'd0 || bus.bypass_dst_o !== 5'd0) $display("FAIL bypass_noalloc: got prd=%0d dst=%0d want 0/0", bus.decoded_rr.prd, bus.bypass_dst_o); else n_pass++;
  endtask

  task automatic test_no_alloc_and_stall();
    decoded_instr_t held;
    issue(mk(0, 1, 2, 1));
    n_checks++; if (bus.decoded_rr.prd !== 7'd0 || bus.free_count !== 7'd94) $display("FAIL rd0_noalloc: got prd=%0d count=%0d want 0/94", bus.decoded_rr.prd, bus.free_count); else n_pass++;
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd32) $display("FAIL rd0_prs1: got %0d want 32", bus.decoded_rr.prs1); else n_pass++;
    held = mk(5, 16, 0, 0);
    issue(held);
    n_checks++; if (bus.decoded_rr.prd !== 7'd0 || bus.decoded_rr.old_prd !== 7'd5 || bus.decoded_rr.prs1 !== 7'd33) $display("FAIL wr0_noalloc: got prd=%0d old=%0d prs1=%0d want 0/5/33", bus.decoded_rr.prd, bus.decoded_rr.old_prd, bus.decoded_rr.prs1); else n_pass++;
    bus.stall = 1'b1;
    issue(mk(7, 3, 3, 1));
    n_checks++; if (bus.decoded_rr.instr !== held || bus.rr_valid_o !== 1'b1 || bus.decoded_rr.old_prd !== 7'd5) $display("FAIL stall_hold: got %h v=%0b want %h v=1", bus.decoded_rr.instr, bus.rr_valid_o, held); else n_pass++;
    n_checks++; if (bus.free_count !== 7'd94) $display("FAIL stall_no_pop: got %0d want 94", bus.free_count); else n_pass++;
    bus.stall = 1'b0;
    issue(mk(0, 7, 0, 0));
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd7) $display("FAIL stall_no_rat_write: got %0d want 7", bus.decoded_rr.prs1); else n_pass++;
    set_idle();
    cycle();
    n_checks++; if (bus.rr_valid_o !== 1'b0) $display("FAIL idle_rr_valid: got %0b want 0", bus.rr_valid_o); else n_pass++;
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < FREE_DEPTH; i++) begin
      issue(mk(1 + (i % 31), $urandom_range(0, 31), $urandom_range(0, 31), 1));
      n_checks++; if (bus.decoded_rr.prd !== PW'(NUM_AREGS + i)) $display("FAIL exhaust_prd_%0d: got %0d want %0d", i, bus.decoded_rr.prd, NUM_AREGS + i); else n_pass++;
    end
    n_checks++; if (bus.empty !== 1'b1 || bus.free_count !== 7'd0 || bus.full !== 1'b0) $display("FAIL exhaust_empty: got empty=%0b count=%0d full=%0b want 1/0/0", bus.empty, bus.free_count, bus.full); else n_pass++;
    bus.decoded_dd = mk(4, 1, 2, 1);
    bus.free_w_en = 1'b1; bus.free_preg_i = 7'd40; #1;
    n_checks++; if (bus.rename_stall_o !== 1'b1) $display("FAIL empty_stall: got %0b want 1", bus.rename_stall_o); else n_pass++;
    cycle();
    n_checks++; if (bus.rr_valid_o !== 1'b0 || bus.free_count !== 7'd1) $display("FAIL empty_stall_out: got v=%0b count=%0d want 0/1", bus.rr_valid_o, bus.free_count); else n_pass++;
    bus.free_w_en = 1'b0; bus.free_preg_i = '0; #1;
    n_checks++; if (bus.rename_stall_o !== 1'b0) $display("FAIL refill_unstall: got %0b want 0", bus.rename_stall_o); else n_pass++;
    cycle();
    n_checks++; if (bus.rr_valid_o !== 1'b1 || bus.decoded_rr.prd !== 7'd40) $display("FAIL refill_prd: got v=%0b prd=%0d want 1/40", bus.rr_valid_o, bus.decoded_rr.prd); else n_pass++;
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int i = 0; i < 86; i++) issue(mk(1 + (i % 31), 0, 0, 1));
    bus.free_w_en = 1'b1; bus.free_preg_i = 7'd5;
    issue(mk(2, 0, 0, 1));
    bus.free_w_en = 1'b0; bus.free_preg_i = '0;
    n_checks++; if (bus.decoded_rr.prd !== 7'd118 || bus.free_count !== 7'd10) $display("FAIL push_pop: got prd=%0d count=%0d want 118/10", bus.decoded_rr.prd, bus.free_count); else n_pass++;
    for (int i = 0; i < 10; i++) issue(mk(3, 0, 0, 1));
    n_checks++; if (bus.decoded_rr.prd !== 7'd5) $display("FAIL pushed_at_tail: got %0d want 5", bus.decoded_rr.prd); else n_pass++;
    set_idle();
    bus.free_w_en = 1'b1; bus.free_preg_i = 7'd0;
    cycle();
    n_checks++; if (bus.free_count !== 7'd0 || bus.empty !== 1'b1) $display("FAIL push_zero: got count=%0d empty=%0b want 0/1", bus.free_count, bus.empty); else n_pass++;
    do_reset();
    bus.free_w_en = 1'b1; bus.free_preg_i = 7'd3;
    cycle();
    bus.free_w_en = 1'b0; bus.free_preg_i = '0;
    n_checks++; if (bus.free_count !== 7'd96 || bus.full !== 1'b1) $display("FAIL push_full: got count=%0d full=%0b want 96/1", bus.free_count, bus.full); else n_pass++;
    issue(mk(6, 0, 0, 1));
    n_checks++; if (bus.decoded_rr.prd !== 7'd32) $display("FAIL push_full_head: got %0d want 32", bus.decoded_rr.prd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    issue(mk(3, 0, 0, 1));
    issue(mk(5, 0, 0, 1));
    rst = 1'b1;
    bus.free_w_en = 1'b1; bus.free_preg_i = 7'd9;
    issue(mk(3, 0, 0, 1));
    rst = 1'b0;
    set_idle();
    n_checks++; if (bus.free_count !== 7'd96 || bus.rr_valid_o !== 1'b0) $display("FAIL midreset_state: got count=%0d v=%0b want 96/0", bus.free_count, bus.rr_valid_o); else n_pass++;
    issue(mk(6, 3, 5, 1));
    n_checks++; if (bus.decoded_rr.prs1 !== 7'd3 || bus.decoded_rr.prs2 !== 7'd5) $display("FAIL midreset_rat: got %0d/%0d want 3/5", bus.decoded_rr.prs1, bus.decoded_rr.prs2); else n_pass++;
    n_checks++; if (bus.decoded_rr.prd !== 7'd32 || bus.decoded_rr.old_prd !== 7'd6) $display("FAIL midreset_head: got prd=%0d old=%0d want 32/6", bus.decoded_rr.prd, bus.decoded_rr.old_prd); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst                = ($urandom_range(0, 399) == 0);
      bus.valid_i        = ($urandom_range(0, 9) < 8);
      bus.stall          = ($urandom_range(0, 9) < 2);
      bus.decoded_dd     = mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3) != 0);
      bus.free_w_en      = ($urandom_range(0, 3) == 0);
      bus.free_preg_i    = PW'($urandom_range(0, 127));
      bus.bypass_dst_i   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : '0;
      bus.bypass_alias_i = PW'($urandom_range(0, 127));
      #1;
      if (!rst) begin
        n_checks++; if (bus.rename_stall_o !== m_rstall()) $display("FAIL rnd_rename_stall @%0d: got %0b want %0b", n, bus.rename_stall_o, m_rstall()); else n_pass++;
      end
      cycle();
      n_checks++; if (bus.rr_valid_o !== m_rr_valid) $display("FAIL rnd_rr_valid @%0d: got %0b want %0b", n, bus.rr_valid_o, m_rr_valid); else n_pass++;
      if (m_rr_valid) begin
        n_checks++; if (bus.decoded_rr !== m_rr) $display("FAIL rnd_decoded_rr @%0d: got %h want %h", n, bus.decoded_rr, m_rr); else n_pass++;
      end
      n_checks++; if (bus.bypass_dst_o !== m_byp_dst || bus.bypass_alias_o !== m_byp_alias) $display("FAIL rnd_bypass_out @%0d: got %0d/%0d want %0d/%0d", n, bus.bypass_dst_o, bus.bypass_alias_o, m_byp_dst, m_byp_alias); else n_pass++;
      n_checks++; if (bus.free_count !== CW'(exp_q.size())) $display("FAIL rnd_count @%0d: got %0d want %0d", n, bus.free_count, exp_q.size()); else n_pass++;
      n_checks++; if (bus.empty !== (exp_q.size() == 0) || bus.full !== (exp_q.size() == FREE_DEPTH)) $display("FAIL rnd_flags @%0d: got empty=%0b full=%0b want size %0d", n, bus.empty, bus.full, exp_q.size()); else n_pass++;
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_basic_rename();
    test_no_alloc_and_stall();
    test_exhaust();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage of the out-of-order core, between decode and dispatch.
- Takes one decoded instruction per cycle and maps architectural source/destination registers to physical registers.
- Built from a register alias table (RAT), a free physical-register list and the rename pipeline register.
- Returns freed pregs from commit into the free list.

Parameters:
NUM_AREGS, 32, architectural registers (areg width AW = clog2 = 5)
NUM_PREGS, 128, physical registers (preg width PW = clog2 = 7)
FREE_DEPTH, NUM_PREGS-NUM_AREGS (96), free-list capacity

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  downstream stall; freezes rename
valid_i  in  1  decoded_dd holds a valid instruction
decoded_dd  in  decoded_instr_t  decoded instruction (rd, rs1, rs2, wr_reg, op, imm, flags)
free_w_en  in  1  commit returns a preg
free_preg_i  in  PW  preg being freed
bypass_dst_i  in  AW  forwarded areg mapping (0 = none)
bypass_alias_i  in  PW  preg for bypass_dst_i
decoded_rr  out  decoded_rr_instr_t  renamed instruction (registered)
rr_valid_o  out  1  decoded_rr valid
bypass_dst_o  out  AW  areg renamed last accepted cycle (0 = none)
bypass_alias_o  out  PW  preg allocated for bypass_dst_o
rename_stall_o  out  1  rename cannot accept instruction this cycle
full  out  1  free list holds FREE_DEPTH entries
empty  out  1  free list holds 0 entries

Behaviour:
- Reset (synchronous, active-high):
  - RAT[i] = i for all i.
  - Free list contains pregs 32..127 in ascending order; head = 32; count = 96.
  - rr_valid_o = 0, decoded_rr = 0, bypass_dst_o = 0, bypass_alias_o = 0.
  - Reset mid-operation discards all in-flight state, including same-cycle pushes.
- needs_alloc = valid_i & decoded_dd.wr_reg & (rd != 0).
- rename_stall_o = valid_i & needs_alloc & empty.
  - empty is the pre-edge value; a same-cycle free does not satisfy the allocation.
- accept = valid_i & !stall & !rename_stall_o.
- Source lookup (combinational), per rsN:
  - areg 0 -> preg 0.
  - Else if bypass_dst_i != 0 and bypass_dst_i == rsN -> bypass_alias_i.
  - Else RAT[rsN].
- old_prd = RAT[rd] (preg 0 if rd == 0).
- On accept with needs_alloc:
  - prd = free-list head; pop; RAT[rd] <= prd at the edge.
  - The next instruction sees the new mapping without bypass.
- On accept without needs_alloc: prd = 0, no pop, no RAT write.
- decoded_rr (1-cycle latency, registered on accept):
  - All decoded_dd fields pass through.
  - Adds prs1, prs2, prd, old_prd.
  - rr_valid_o <= 1.
- Not accepted:
  - stall = 1: decoded_rr and rr_valid_o hold.
  - Otherwise rr_valid_o <= 0.
- bypass_dst_o / bypass_alias_o:
  - On accept with needs_alloc, register (rd, prd).
  - On accept without alloc, set dst 0.
  - Hold otherwise.
- Free list: circular FIFO, FREE_DEPTH entries, head/tail wrap modulo FREE_DEPTH.
  - Push (free_w_en) is independent of stall.
  - Push and pop in the same cycle: count unchanged.
  - Push while full is ignored.
  - Push of preg 0 is ignored.
  - Pop never occurs when empty.
- Exactly one rename per cycle; no multi-issue.

Decomposition:
- Shared package / define.svh holds:
  - NUM_AREGS, NUM_PREGS.
  - decoded_instr_t, decoded_rr_instr_t (decoded_instr_t plus prs1, prs2, prd, old_prd, each PW wide).
  - Opcode enum (ADD_I, ...).
- One sub-module: preg_free_list (FIFO with w_en, r_en, preg_in, preg_out, full, empty).
- RAT array and rename logic stay in rename_stage.

Test Plan:
- Reset, then rd=1, rs1=2, rs2=3, wr_reg=1 -> next cycle prs1=2, prs2=3, prd=32, old_prd=1, rr_valid_o=1; bypass_dst_o=1, bypass_alias_o=32.
- Follow with rd=16, rs1=1, rs2=4 -> prs1=32 (RAT updated), prs2=4, prd=33, old_prd=16.
- bypass_dst_i=8, bypass_alias_i=127, rs1=8, rs2=0 -> prs1=127, prs2=0.
- rd=0 or wr_reg=0 -> prd=0, no pop (count unchanged), RAT unchanged; stall=1 holds decoded_rr and blocks the RAT write.
- 96 back-to-back allocations -> empty=1; the 97th instruction asserts rename_stall_o, rr_valid_o=0. Free preg 40 -> the following cycle accepts with prd=40.
- Simultaneous push (preg 5) and pop at count 10 -> count stays 10, popped value is old head. Push at full is ignored. Reset mid-stream restores RAT[i]=i and count=96.
